// File: rtl/logic_unit_ctrl.sv
// rtl/logic_unit_ctrl.sv - sequencing controller for the AND/OR/XOR/shift logic unit
// Accepts one request at a time, iterates shifts one bit per clock, holds the result until taken.
module logic_unit_ctrl #(
   parameter int DATA_W = 32,
   parameter int RES_W  = 67,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [CNT_W-1:0]  shamt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RES_W-1:0]  result,
   output logic              err,
   output logic              busy
);

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_LSH = 3'd3;
   localparam logic [2:0] OP_RSH = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [2:0]        r_op;
   logic [DATA_W-1:0] r_b;
   logic [RES_W-1:0]  r_work;
   logic [CNT_W-1:0]  r_cnt;
   logic [RES_W-1:0]  r_result;
   logic              r_err;

   logic              w_accept;
   logic              w_in_shift;
   logic              w_is_shift;
   logic              w_illegal;
   logic [DATA_W-1:0] w_logic;

   assign in_ready   = (r_state == S_IDLE);
   assign out_valid  = (r_state == S_DONE);
   assign busy       = (r_state != S_IDLE);
   assign result     = r_result;
   assign err        = r_err;

   assign w_accept   = in_valid & in_ready;
   assign w_in_shift = (op == OP_LSH) || (op == OP_RSH);
   assign w_is_shift = (r_op == OP_LSH) || (r_op == OP_RSH);
   assign w_illegal  = (r_op > OP_RSH);

   // The low half of the work register still holds operand A for logic ops.
   always_comb begin
      w_logic = '0;
      case (r_op)
         OP_AND:  w_logic = r_work[DATA_W-1:0] & r_b;
         OP_OR:   w_logic = r_work[DATA_W-1:0] | r_b;
         OP_XOR:  w_logic = r_work[DATA_W-1:0] ^ r_b;
         default: w_logic = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (w_illegal || !w_is_shift || (r_cnt == '0)) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= '0;
         r_b      <= '0;
         r_work   <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else if (w_accept) begin
         r_op   <= op;
         r_b    <= b;
         r_work <= RES_W'(a);
         r_cnt  <= w_in_shift ? shamt : '0;
      end else if (r_state == S_EXEC) begin
         if (w_illegal) begin
            r_result <= '0;
            r_err    <= 1'b1;
         end else if (!w_is_shift) begin
            r_result <= RES_W'(w_logic);
            r_err    <= 1'b0;
         end else if (r_cnt == '0) begin
            r_result <= r_work;
            r_err    <= 1'b0;
         end else begin
            // Logical shifts: zeros enter from either end.
            r_work <= (r_op == OP_LSH) ? (r_work << 1) : (r_work >> 1);
            r_cnt  <= r_cnt - CNT_W'(1);
         end
      end
   end

endmodule
